uart_rx_fifo: RTL and testbench

//  Parametrised buffered UART receiver; successor to the fixed 8N1 buffered RX.

---
 rtl/uart_rx_fifo.sv | 98 +++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with optional parity and stop-bit checking,
// queuing good bytes in a first-word-fall-through FIFO with fill level and error flags.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int FIFO_DEPTH   = 16,
   parameter int AW           = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   input  logic                 ren,
   output logic [DATA_BITS-1:0] out,
   output logic                 ready,
   output logic [AW:0]          count,
   output logic                 frame_err,
   output logic                 par_err,
   output logic                 overflow,
   input  logic                 err_clr
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;
   state_t st, nxt;
   logic rx_m, rx_s, tick, half, push, f_err, p_err, par_bad, pop, full, wr;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign tick = cnt == CW'(CLKS_PER_BIT - 1);
   assign half = cnt == CW'(CLKS_PER_BIT / 2);
   always_ff @(posedge clk)
      st <= rst ? IDLE : nxt;
   // The counter restarts at the start-bit centre, so every later tick lands on a bit centre.
   always_comb begin
      nxt   = st;
      push  = 1'b0;
      f_err = 1'b0;
      p_err = 1'b0;
      case (st)
         IDLE:    nxt = rx_s ? IDLE : START;
         START:   nxt = !half ? START : rx_s ? IDLE : DATA;
         DATA:    nxt = (tick && bit_idx == 3'(DATA_BITS - 1)) ? (PARITY != 0 ? PAR : STOP) : DATA;
         PAR:     nxt = tick ? STOP : PAR;
         STOP: begin
            nxt   = !tick ? STOP : rx_s ? IDLE : WAIT_HI;
            f_err = tick && !rx_s;
            p_err = tick && rx_s && par_bad;
            push  = tick && rx_s && !par_bad;
         end
         WAIT_HI: nxt = rx_s ? IDLE : WAIT_HI;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         sh        <= '0;
         par_bad   <= 1'b0;
         frame_err <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         rx_m      <= rx_in;
         rx_s      <= rx_m;
         cnt       <= (nxt != st || tick || st == IDLE) ? '0 : cnt + CW'(1);
         bit_idx   <= st != DATA ? '0 : bit_idx + 3'(tick);
         if (st == DATA && tick) sh <= {rx_s, sh[DATA_BITS-1:1]};
         if (st == PAR && tick) par_bad <= ^{sh, rx_s} ^ (PARITY == 1);
         frame_err <= f_err;
         par_err   <= p_err;
      end
   end
   assign full  = count == (AW+1)'(FIFO_DEPTH);
   assign ready = count != '0;
   assign pop   = ren && ready;
   assign wr    = push && (!full || pop);
   assign out   = ready ? mem[rd_ptr] : '0;
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= sh;
   // A push coinciding with a pop on a full FIFO reuses the slot being vacated.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(wr);
         rd_ptr   <= rd_ptr + AW'(pop);
         count    <= count + (AW+1)'(wr && !pop) - (AW+1)'(pop && !wr);
         overflow <= (push && full && !pop) || (overflow && !err_clr);
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frames on an 8N1 and an 8E1 receiver, checked
// against a byte-queue model of the FIFO contents and flags.
module tb_uart_rx_fifo;
   localparam int CPB = 16;
   logic clk = 1'b0, rst = 1'b1, rx_a = 1'b1, rx_b = 1'b1, ren_a = 1'b0, ren_b = 1'b0, err_clr = 1'b0;
   logic [7:0] out_a, out_b, d;
   logic [4:0] count_a, count_b;
   logic ready_a, ready_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, ova = 1'b0, ovb = 1'b0, bad;
   int n_vec = 0, n_err = 0, fe_na = 0, pe_na = 0, fe_nb = 0, pe_nb = 0, fe0, pe0, pe_exp;
   logic [7:0] qa[$], qb[$];
   logic [7:0] msg [7] = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h2B, 8'h20, 8'h0A};

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16), .AW(4)) dut_a (
      .clk(clk), .rst(rst), .rx_in(rx_a), .ren(ren_a), .out(out_a), .ready(ready_a), .count(count_a),
      .frame_err(fe_a), .par_err(pe_a), .overflow(ov_a), .err_clr(err_clr));
   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16), .AW(4)) dut_b (
      .clk(clk), .rst(rst), .rx_in(rx_b), .ren(ren_b), .out(out_b), .ready(ready_b), .count(count_b),
      .frame_err(fe_b), .par_err(pe_b), .overflow(ov_b), .err_clr(err_clr));

   always #4 clk = ~clk;
   always @(posedge clk) begin
      fe_na <= fe_na + int'(fe_a);
      pe_na <= pe_na + int'(pe_a);
      fe_nb <= fe_nb + int'(fe_b);
      pe_nb <= pe_nb + int'(pe_b);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic look_a(input string t);
      chk({t, ".count_a"}, 32'(count_a), 32'(qa.size()));
      chk({t, ".ready_a"}, 32'(ready_a), 32'(qa.size() != 0));
      chk({t, ".out_a"}, 32'(out_a), qa.size() != 0 ? 32'(qa[0]) : 32'd0);
      chk({t, ".ovf_a"}, 32'(ov_a), 32'(ova));
   endtask

   task automatic look_b(input string t);
      chk({t, ".count_b"}, 32'(count_b), 32'(qb.size()));
      chk({t, ".out_b"}, 32'(out_b), qb.size() != 0 ? 32'(qb[0]) : 32'd0);
      chk({t, ".ovf_b"}, 32'(ov_b), 32'(ovb));
   endtask

   task automatic mpush_a(input logic [7:0] v);
      if (qa.size() == 16) ova = 1'b1;
      else qa.push_back(v);
   endtask

   task automatic mpush_b(input logic [7:0] v);
      if (qb.size() == 16) ovb = 1'b1;
      else qb.push_back(v);
   endtask

   // One frame, LSB first; pp raises ren_a for exactly the cycle whose edge samples the stop bit.
   task automatic send(input bit b, input logic [7:0] v, input bit p, input bit stop, input bit pp);
      logic [10:0] f;
      int n;
      n = b ? 11 : 10;
      f = b ? {stop, p, v, 1'b0} : {1'b1, stop, v, 1'b0};
      for (int k = 0; k < n * CPB; k++) begin
         @(negedge clk);
         if (b) rx_b = f[k / CPB];
         else rx_a = f[k / CPB];
         ren_a = pp && k == CPB * (n - 1) + CPB / 2 + 3;
      end
      @(negedge clk);
      ren_a = 1'b0;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic pop_a(input string t);
      chk({t, ".rdy"}, 32'(ready_a), 32'(qa.size() != 0));
      chk({t, ".head"}, 32'(out_a), qa.size() != 0 ? 32'(qa[0]) : 32'd0);
      ren_a = 1'b1;
      @(negedge clk);
      ren_a = 1'b0;
      if (qa.size() != 0) qa.delete(0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      look_a("rst");
      look_b("rst");
      chk("rst.flags", 32'({fe_a, pe_a, fe_b, pe_b}), 32'd0);

      for (int i = 0; i < 7; i++) begin
         send(1'b0, msg[i], 1'b0, 1'b1, 1'b0);
         mpush_a(msg[i]);
      end
      look_a("msg");
      for (int i = 0; i < 7; i++) pop_a("msg.pop");
      look_a("msg.empty");
      ren_a = 1'b1;
      @(negedge clk);
      ren_a = 1'b0;
      look_a("ren_empty");

      for (int i = 0; i < 17; i++) begin
         send(1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
         mpush_a(8'(i));
      end
      look_a("full");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      ova = 1'b0;
      look_a("err_clr");
      for (int i = 0; i < 40; i++) begin
         pop_a("wrap.pop");
         d = 8'($urandom);
         send(1'b0, d, 1'b0, 1'b1, 1'b0);
         mpush_a(d);
         if (i % 8 == 7) look_a("wrap");
      end
      for (int i = 0; i < 16; i++) pop_a("drain");
      look_a("drained");

      pe0 = pe_nb;
      send(1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
      chk("par.bad_pulse", 32'(pe_nb - pe0), 32'd1);
      look_b("par.bad");
      send(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
      mpush_b(8'h41);
      chk("par.good_nopulse", 32'(pe_nb - pe0), 32'd1);
      look_b("par.good");
      pe_exp = pe_nb;
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         bad = 1'($urandom);
         send(1'b1, d, ^d ^ bad, 1'b1, 1'b0);
         if (bad) pe_exp++;
         else mpush_b(d);
         chk("par.rand_pulses", 32'(pe_nb), 32'(pe_exp));
         look_b("par.rand");
      end
      fe0 = fe_nb;
      pe0 = pe_nb;
      d = 8'($urandom);
      send(1'b1, d, ~(^d), 1'b0, 1'b0);
      repeat (3 * CPB) @(negedge clk);
      chk("frame.fe_pulse", 32'(fe_nb - fe0), 32'd1);
      chk("frame.no_par", 32'(pe_nb - pe0), 32'd0);
      look_b("frame.dropped");
      rx_b = 1'b1;
      repeat (CPB) @(negedge clk);
      d = 8'($urandom);
      send(1'b1, d, ^d, 1'b1, 1'b0);
      mpush_b(d);
      look_b("frame.recover");
      chk("frame.fe_once", 32'(fe_nb - fe0), 32'd1);

      fe0 = fe_na;
      pe0 = pe_na;
      @(negedge clk);
      rx_a = 1'b0;
      repeat (5) @(negedge clk);
      rx_a = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch.flags", 32'((fe_na - fe0) + (pe_na - pe0)), 32'd0);
      look_a("glitch");
      d = 8'($urandom);
      send(1'b0, d, 1'b0, 1'b1, 1'b0);
      mpush_a(d);
      look_a("glitch.next");

      for (int i = 0; i < 15; i++) begin
         d = 8'($urandom);
         send(1'b0, d, 1'b0, 1'b1, 1'b0);
         mpush_a(d);
      end
      look_a("refill");
      d = 8'($urandom);
      send(1'b0, d, 1'b0, 1'b1, 1'b1);
      qa.delete(0);
      qa.push_back(d);
      look_a("pushpop_full");
      @(negedge clk);
      rx_a = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rx_a = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      qa.delete();
      qb.delete();
      ova = 1'b0;
      ovb = 1'b0;
      repeat (CPB) @(negedge clk);
      look_a("midrst");
      look_b("midrst");
      d = 8'($urandom);
      send(1'b0, d, 1'b0, 1'b1, 1'b0);
      mpush_a(d);
      look_a("midrst.next");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
